// File: rtl/stream_mux_arb.sv
// N-to-1 valid/ready stream mux with fixed-select or round-robin arbitration and a registered output.
// One cycle from input transfer to output. Every in_ready drops while the output word is stalled.
module stream_mux_arb #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);
  localparam int NPAD = 1 << SEL_W;

  logic [WIDTH-1:0] chan_dat [CHANNELS];
  logic [NPAD-1:0]  valid_pad;
  logic [NPAD-1:0]  ready_pad;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             valid_q, valid_d;
  logic             load, xfer, grant_vld;
  logic [SEL_W-1:0] grant;
  logic [SEL_W:0]   cand;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
    assign chan_dat[g] = in_data[g*WIDTH +: WIDTH];
  end

  // Zero padding makes a select beyond the last channel read as "not valid".
  assign valid_pad = NPAD'(in_valid);
  assign load      = !valid_q || out_ready;

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    cand      = '0;
    if (!mode) begin
      if (valid_pad[select]) begin
        grant_vld = 1'b1;
        grant     = select;
      end
    end else begin
      for (int k = 1; k <= CHANNELS; k++) begin
        cand = {1'b0, ptr_q} + (SEL_W+1)'(k);
        if (cand >= (SEL_W+1)'(CHANNELS)) cand = cand - (SEL_W+1)'(CHANNELS);
        if (!grant_vld && valid_pad[cand[SEL_W-1:0]]) begin
          grant_vld = 1'b1;
          grant     = cand[SEL_W-1:0];
        end
      end
    end
  end

  assign xfer      = load && grant_vld && !rst;
  assign ready_pad = NPAD'(1) << grant;
  assign in_ready  = xfer ? ready_pad[CHANNELS-1:0] : '0;
  assign ptr_d     = xfer ? grant : ptr_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    chan_d  = chan_q;
    if (load) begin
      valid_d = grant_vld;
      if (grant_vld) begin
        data_d = chan_dat[grant];
        chan_d = grant;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= SEL_W'(CHANNELS - 1);
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_chan  = chan_q;
endmodule

// File: doc/stream_mux_arb.md
# stream_mux_arb

Parametrised N-to-1 streaming multiplexer: `CHANNELS` input channels of `WIDTH` bits, each with a valid/ready handshake, merged into one registered output stream. It supports two modes:
- **Fixed-select**: the channel index on `select` is forwarded.
- **Round-robin**: the block arbitrates fairly among the channels asserting valid.

It replaces the combinational fixed-width mux trees in datapaths that need back-pressure, fairness and a registered output.

## Interface
- `WIDTH`, 8, data bits per channel (≥1)
- `CHANNELS`, 8, number of input channels (2..16; not required to be a power of 2)
- `SEL_W`, `$clog2(CHANNELS)`, width of `select` and `out_chan` (derived; do not override)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_data`  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- `in_valid`  in  CHANNELS  per-channel valid
- `in_ready`  out  CHANNELS  per-channel ready; combinational; at most one bit high
- `mode`  in  1  0 = fixed-select, 1 = round-robin
- `select`  in  SEL_W  channel index, used only when `mode` = 0
- `out_data`  out  WIDTH  registered output data
- `out_valid`  out  1  registered output valid
- `out_chan`  out  SEL_W  index of the channel that supplied `out_data`
- `out_ready`  in  1  downstream ready

## Operation
- **Transfer rules**
  - Input transfer on channel i: `in_valid[i]` && `in_ready[i]` at a rising edge.
  - Output transfer: `out_valid` && `out_ready`.
- **Load enable**: `load = !out_valid || out_ready`. The output register accepts new data only when `load` is 1.
- **Grant (combinational, every cycle)**
  - `mode` = 0: grant = `select` if `select` < CHANNELS and `in_valid[select]`; otherwise no grant. Other channels' valids are ignored.
  - `mode` = 1: grant = first i with `in_valid[i]`, searching from `(ptr+1) mod CHANNELS` upward with wrap-around. No grant if `in_valid` is all zero.
- **Ready**: `in_ready[i]` = `load` && grant valid && grant == i. All ready bits are low when there is no grant.
- **On a cycle with `load` = 1**
  - Grant present: `out_data` <= granted channel data, `out_chan` <= grant, `out_valid` <= 1.
  - No grant: `out_valid` <= 0; `out_data` and `out_chan` hold their values.
- **On a cycle with `load` = 0**: all output registers hold. Output is stable while `out_valid` && !`out_ready` (AXI-style).
- **Round-robin pointer `ptr`**
  - Updates to the granted index on every input transfer, in either mode.
  - A fixed-mode transfer therefore moves the fairness point.
  - `ptr` is never updated without a transfer.
- **Mode/select changes**: sampled combinationally and take effect on the next grant decision. A word already in the output register is unaffected.
- **Inputs**: `in_data` and `in_valid` are not required to be held stable by this block, since the grant is re-evaluated each cycle. Upstream sources must nonetheless follow valid/ready rules.

## Timing
- **Reset** (asynchronous assert, synchronous release by the system):
  - `out_valid` = 0, `out_data` = 0, `out_chan` = 0.
  - `ptr` = CHANNELS-1, so the first round-robin search starts at channel 0.
  - `in_ready` = all 0 while `rst` is high.
- **Reset mid-operation**: the word held in the output register is dropped. No partial handshake survives reset.
- **Latency**: one cycle from input transfer to `out_valid`/`out_data` visible.
- **Throughput**
  - One word per cycle when `out_ready` is held high.
  - Back-to-back transfers from the same channel are allowed: in round-robin only when no other channel is valid; in fixed mode, always.
- **Back-pressure**: when `out_valid` = 1 and `out_ready` = 0, all `in_ready` bits are 0 in that cycle.
- **Simultaneous output drain and new grant**: legal in the same cycle. The output register is replaced with no bubble.
- **Out-of-range select** (`select` ≥ CHANNELS, non-power-of-2 CHANNELS): no grant, no transfer, no X propagation.

## Test plan
- **Reset**: assert `rst` mid-stream with `out_valid` = 1 → `out_valid`, `out_data`, `out_chan` read 0 immediately (asynchronously). After release with `mode` = 1 and all valid, the first grant is channel 0.
- **Fixed mode**: WIDTH = 8, CHANNELS = 8, `mode` = 0, `out_ready` = 1, `in_data` = {190,140,170,130,150,120,150,100} (channel 7..0), all valid.
  - `select` = 5 → next cycle `out_data` = 170, `out_chan` = 5.
  - `select` = 6 → 140.
  - `select` = 1 → 150.
  - `select` = 7 → 190.
  - Only the selected `in_ready` bit is high each cycle.
- **Round-robin fairness**: `mode` = 1, all 8 valid, `out_ready` = 1 for 16 cycles → `out_chan` sequence 0,1,…,7,0,…,7.
- **Round-robin with sparse valids**: only channels 2 and 6 valid → grants alternate 2,6,2,6.
- **Back-pressure**: hold `out_ready` = 0 for 3 cycles while `out_valid` = 1 → `out_data`/`out_chan` stable, `in_ready` = 0, `ptr` unchanged. On release, a new grant occurs in the same cycle the held word drains, with no bubble.
- **Boundary**:
  - CHANNELS = 5, `mode` = 0, `select` = 6 with all valid → `in_ready` = 0, `out_valid` falls to 0 after drain.
  - `mode` switched 0→1 after a fixed-mode grant on channel 3 → next round-robin grant is channel 4.
